// File: rtl/timer_ctrl_master_if.sv
// Avalon-MM bus between timer_ctrl_master and the interval timer slave.
// The slave has no waitrequest. Read data arrives one cycle after the read strobe.
interface timer_ctrl_master_if;
  logic [2:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [15:0] avm_writedata;
  logic [15:0] avm_readdata;
  logic        avm_irq;

  modport master (
    output avm_address, avm_chipselect, avm_write_n, avm_writedata,
    input  avm_readdata, avm_irq
  );

  modport slave (
    input  avm_address, avm_chipselect, avm_write_n, avm_writedata,
    output avm_readdata, avm_irq
  );
endinterface

// File: rtl/timer_ctrl_master.sv
// timer_ctrl_master: hardware-only driver for the 16-bit-register interval timer.
// It writes the period and starts the timer. It waits for a timeout, either on the IRQ
// or by polling the status register. On each timeout it clears the status and emits one
// tick. It stops the timer when asked.
// Optional feature macro SNAPSHOT_READ_EN adds a snapshot read path
// (snap_req / snap_value / snap_valid).
module timer_ctrl_master #(
  parameter int TICK_W   = 16,
  parameter int USE_IRQ  = 1,
  parameter int POLL_GAP = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_start,
  input  logic                 cmd_stop,
  input  logic [31:0]          cmd_period,
  input  logic                 cmd_continuous,
  output logic                 busy,
  output logic                 tick,
  output logic [TICK_W-1:0]    tick_count,
  timer_ctrl_master_if.master  avm
`ifdef SNAPSHOT_READ_EN
  ,
  input  logic                 snap_req,
  output logic [31:0]          snap_value,
  output logic                 snap_valid
`endif
);

  localparam int   GAP_W = $clog2(POLL_GAP + 1);
  localparam logic ITO   = (USE_IRQ != 0);

`ifdef SNAPSHOT_READ_EN
  typedef enum logic [3:0] {
    IDLE, WR_PL, WR_PH, WR_CTRL, WAIT_EVT, POLL_RD, POLL_CHK, CLR_STS, WR_STOP, FLUSH,
    SNAP_WR, SNAP_RDL, SNAP_RDH, SNAP_CAP
  } state_t;
`else
  typedef enum logic [3:0] {
    IDLE, WR_PL, WR_PH, WR_CTRL, WAIT_EVT, POLL_RD, POLL_CHK, CLR_STS, WR_STOP, FLUSH
  } state_t;
`endif

  state_t             state_q, state_d;
  logic [31:0]        period_q;
  logic               cont_q;
  logic               stop_pend;
  logic [GAP_W-1:0]   gap_cnt;
  logic               gap_done;
  logic               start_acc;
`ifdef SNAPSHOT_READ_EN
  logic               snap_pend;
  logic [15:0]        snap_lo;
`endif

  assign start_acc = (state_q == IDLE) && cmd_start && (cmd_period != 32'd0);
  assign gap_done  = (gap_cnt == GAP_W'(POLL_GAP - 1));
  assign busy      = (state_q != IDLE);

  // State register; reset abandons any sequence in flight
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and one-cycle bus strobes, all decoded from the current state
  always_comb begin
    state_d            = state_q;
    avm.avm_chipselect = 1'b0;
    avm.avm_write_n    = 1'b1;
    avm.avm_address    = 3'd0;
    avm.avm_writedata  = 16'd0;
    tick               = 1'b0;
    case (state_q)
      IDLE: if (start_acc) state_d = WR_PL;
      WR_PL: begin
        avm.avm_chipselect = 1'b1; avm.avm_write_n = 1'b0;
        avm.avm_address = 3'd2; avm.avm_writedata = period_q[15:0];
        state_d = WR_PH;
      end
      WR_PH: begin
        avm.avm_chipselect = 1'b1; avm.avm_write_n = 1'b0;
        avm.avm_address = 3'd3; avm.avm_writedata = period_q[31:16];
        state_d = WR_CTRL;
      end
      // START wins over the reload-stop that the period write triggers in the slave
      WR_CTRL: begin
        avm.avm_chipselect = 1'b1; avm.avm_write_n = 1'b0;
        avm.avm_address = 3'd1; avm.avm_writedata = {12'd0, 1'b0, 1'b1, cont_q, ITO};
        state_d = WAIT_EVT;
      end
      // Timeout first, then a pending stop, then a pending snapshot
      WAIT_EVT: begin
        if (USE_IRQ != 0 && avm.avm_irq)  state_d = CLR_STS;
        else if (stop_pend)               state_d = WR_STOP;
`ifdef SNAPSHOT_READ_EN
        else if (snap_pend)               state_d = SNAP_WR;
`endif
        else if (USE_IRQ == 0 && gap_done) state_d = POLL_RD;
      end
      POLL_RD: begin
        avm.avm_chipselect = 1'b1;
        state_d = POLL_CHK;
      end
      POLL_CHK: state_d = avm.avm_readdata[0] ? CLR_STS : WAIT_EVT;
      CLR_STS: begin
        avm.avm_chipselect = 1'b1; avm.avm_write_n = 1'b0;
        tick = 1'b1;
        if (stop_pend)    state_d = WR_STOP;
        else if (!cont_q) state_d = IDLE;
        else              state_d = WAIT_EVT;
      end
      WR_STOP: begin
        avm.avm_chipselect = 1'b1; avm.avm_write_n = 1'b0;
        avm.avm_address = 3'd1; avm.avm_writedata = 16'h0008;
        state_d = FLUSH;
      end
      // Clears a timeout that raced the stop; deliberately no tick
      FLUSH: begin
        avm.avm_chipselect = 1'b1; avm.avm_write_n = 1'b0;
        state_d = IDLE;
      end
`ifdef SNAPSHOT_READ_EN
      SNAP_WR: begin
        avm.avm_chipselect = 1'b1; avm.avm_write_n = 1'b0;
        avm.avm_address = 3'd4;
        state_d = SNAP_RDL;
      end
      SNAP_RDL: begin
        avm.avm_chipselect = 1'b1; avm.avm_address = 3'd4;
        state_d = SNAP_RDH;
      end
      SNAP_RDH: begin
        avm.avm_chipselect = 1'b1; avm.avm_address = 3'd5;
        state_d = SNAP_CAP;
      end
      SNAP_CAP: state_d = WAIT_EVT;
`endif
      default: state_d = IDLE;
    endcase
  end

  // Command latches, the stop request and the tick counter
  always_ff @(posedge clk) begin
    if (reset) begin
      period_q   <= 32'd0;
      cont_q     <= 1'b0;
      stop_pend  <= 1'b0;
      tick_count <= '0;
    end else begin
      if (start_acc) begin
        period_q   <= cmd_period;
        cont_q     <= cmd_continuous;
        stop_pend  <= 1'b0;
        tick_count <= '0;
      end else if (cmd_stop && state_q != IDLE) begin
        stop_pend  <= 1'b1;
      end
      if (state_q == CLR_STS) tick_count <= tick_count + TICK_W'(1);
    end
  end

  // Idle cycles spent in WAIT_EVT; restarts every time WAIT_EVT is entered
  always_ff @(posedge clk) begin
    if (reset) gap_cnt <= '0;
    else       gap_cnt <= (state_q == WAIT_EVT && state_d == WAIT_EVT) ? gap_cnt + GAP_W'(1) : '0;
  end

`ifdef SNAPSHOT_READ_EN
  // Snapshot request and capture; snap_value and snap_valid update together
  always_ff @(posedge clk) begin
    if (reset) begin
      snap_pend  <= 1'b0;
      snap_lo    <= 16'd0;
      snap_value <= 32'd0;
      snap_valid <= 1'b0;
    end else begin
      if (start_acc)                          snap_pend <= 1'b0;
      else if (snap_req && state_q != IDLE)   snap_pend <= 1'b1;
      else if (state_d == SNAP_WR)            snap_pend <= 1'b0;
      if (state_q == SNAP_RDH) snap_lo <= avm.avm_readdata;
      if (state_q == SNAP_CAP) snap_value <= {avm.avm_readdata, snap_lo};
      snap_valid <= (state_q == SNAP_CAP);
    end
  end
`endif

endmodule

// File: tb/tb_timer_ctrl_master.sv
// Bench for timer_ctrl_master. It has two instances: inst0 uses the IRQ and inst1 polls
// (POLL_GAP=8). A transaction-level model keeps a queue of expected bus beats per instance
// and is compared every cycle. Directed literal checks pin the model.
// Set the SNAPSHOT_READ_EN macro to include the snapshot path.
module tb_timer_ctrl_master;
  localparam int GAP = 8;
  localparam logic [2:0] K_PL = 3'd0, K_CHK = 3'd1, K_CLR = 3'd2, K_END = 3'd3,
                         K_RDH = 3'd4, K_CAP = 3'd5;
  typedef struct packed {
    logic        cs;
    logic        wr_n;
    logic [2:0]  addr;
    logic [15:0] data;
    logic [2:0]  kind;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, cmd_start, cmd_stop, cmd_cont, irq;
  logic [31:0]       cmd_period;
  logic [15:0]       rdata;
  logic [1:0]        busy, tick;
  logic [1:0][15:0]  cnt;
  logic [1:0][20:0]  bw;
`ifdef SNAPSHOT_READ_EN
  logic              snap_req;
  logic [1:0][31:0]  sval;
  logic [1:0]        svld;
`endif

  timer_ctrl_master_if bus0 ();
  timer_ctrl_master_if bus1 ();
  assign bus0.avm_readdata = rdata;
  assign bus0.avm_irq      = irq;
  assign bus1.avm_readdata = rdata;
  assign bus1.avm_irq      = irq;
  assign bw[0] = {bus0.avm_chipselect, bus0.avm_write_n, bus0.avm_address, bus0.avm_writedata};
  assign bw[1] = {bus1.avm_chipselect, bus1.avm_write_n, bus1.avm_address, bus1.avm_writedata};

  timer_ctrl_master #(.TICK_W(16), .USE_IRQ(1), .POLL_GAP(GAP)) u_irq (
    .clk(clk), .reset(reset), .cmd_start(cmd_start), .cmd_stop(cmd_stop),
    .cmd_period(cmd_period), .cmd_continuous(cmd_cont),
    .busy(busy[0]), .tick(tick[0]), .tick_count(cnt[0]), .avm(bus0)
`ifdef SNAPSHOT_READ_EN
    , .snap_req(snap_req), .snap_value(sval[0]), .snap_valid(svld[0])
`endif
  );

  timer_ctrl_master #(.TICK_W(16), .USE_IRQ(0), .POLL_GAP(GAP)) u_poll (
    .clk(clk), .reset(reset), .cmd_start(cmd_start), .cmd_stop(cmd_stop),
    .cmd_period(cmd_period), .cmd_continuous(cmd_cont),
    .busy(busy[1]), .tick(tick[1]), .tick_count(cnt[1]), .avm(bus1)
`ifdef SNAPSHOT_READ_EN
    , .snap_req(snap_req), .snap_value(sval[1]), .snap_valid(svld[1])
`endif
  );

  int n_chk = 0, n_err = 0;

  // Model: a busy flag, pending requests and a queue of expected bus beats.
  // When the queue is empty and the model is busy, it is waiting for an event.
  beat_t       qb [2][4];
  int          qn [2];
  logic        m_busy [2], m_cont [2], m_stop [2], m_snap [2], m_svld [2];
  logic [31:0] m_sv [2];
  logic [15:0] m_lo [2];
  int          m_cnt [2], m_gap [2];

  function automatic beat_t mk(logic cs, logic wr_n, logic [2:0] a, logic [15:0] d, logic [2:0] k);
    beat_t b;
    b.cs = cs; b.wr_n = wr_n; b.addr = a; b.data = d; b.kind = k;
    return b;
  endfunction

  task automatic push(int i, beat_t b);
    qb[i][qn[i]] = b;
    qn[i]++;
  endtask

  task automatic push_stop(int i);
    push(i, mk(1'b1, 1'b0, 3'd1, 16'h0008, K_PL));
    push(i, mk(1'b1, 1'b0, 3'd0, 16'h0000, K_END));
  endtask

  // Predict the state after the coming clock edge from the inputs driven now
  task automatic advance(int i);
    beat_t b;
    bit irq_mode;
    int ctrl;
    irq_mode = (i == 0);
    if (reset) begin
      m_busy[i] = 0; qn[i] = 0; m_cnt[i] = 0; m_stop[i] = 0; m_snap[i] = 0;
      m_gap[i] = 0; m_sv[i] = 0; m_svld[i] = 0; m_lo[i] = 0; m_cont[i] = 0;
      return;
    end
    m_svld[i] = 0;
    if (!m_busy[i]) begin
      if (cmd_start && cmd_period != 0) begin
        m_busy[i] = 1; m_cont[i] = cmd_cont; m_cnt[i] = 0; m_stop[i] = 0; m_snap[i] = 0;
        ctrl = 4 + (cmd_cont ? 2 : 0) + (irq_mode ? 1 : 0);
        push(i, mk(1'b1, 1'b0, 3'd2, cmd_period[15:0], K_PL));
        push(i, mk(1'b1, 1'b0, 3'd3, cmd_period[31:16], K_PL));
        push(i, mk(1'b1, 1'b0, 3'd1, 16'(ctrl), K_PL));
      end
    end else begin
      if (qn[i] > 0) begin
        b = qb[i][0];
        for (int k = 0; k < 3; k++) qb[i][k] = qb[i][k+1];
        qn[i]--;
        m_gap[i] = 0;
        case (b.kind)
          K_CHK: if (rdata[0]) push(i, mk(1'b1, 1'b0, 3'd0, 16'd0, K_CLR));
          K_CLR: begin
            m_cnt[i]++;
            if (m_stop[i])      push_stop(i);
            else if (!m_cont[i]) m_busy[i] = 0;
          end
          K_END: m_busy[i] = 0;
          K_RDH: m_lo[i] = rdata;
          K_CAP: begin m_sv[i] = {rdata, m_lo[i]}; m_svld[i] = 1; end
          default: ;
        endcase
      end else if (irq_mode && irq) begin
        push(i, mk(1'b1, 1'b0, 3'd0, 16'd0, K_CLR));
      end else if (m_stop[i]) begin
        push_stop(i);
`ifdef SNAPSHOT_READ_EN
      end else if (m_snap[i]) begin
        m_snap[i] = 0;
        push(i, mk(1'b1, 1'b0, 3'd4, 16'd0, K_PL));
        push(i, mk(1'b1, 1'b1, 3'd4, 16'd0, K_PL));
        push(i, mk(1'b1, 1'b1, 3'd5, 16'd0, K_RDH));
        push(i, mk(1'b0, 1'b1, 3'd0, 16'd0, K_CAP));
`endif
      end else if (!irq_mode) begin
        if (m_gap[i] == GAP - 1) begin
          push(i, mk(1'b1, 1'b1, 3'd0, 16'd0, K_PL));
          push(i, mk(1'b0, 1'b1, 3'd0, 16'd0, K_CHK));
        end else begin
          m_gap[i]++;
        end
      end
      if (cmd_stop) m_stop[i] = 1;
`ifdef SNAPSHOT_READ_EN
      if (snap_req) m_snap[i] = 1;
`endif
    end
  endtask

  task automatic compare(int i);
    beat_t b;
    logic [38:0] exp_v, got_v;
    b = (qn[i] > 0) ? qb[i][0] : mk(1'b0, 1'b1, 3'd0, 16'd0, K_PL);
    exp_v = {b.cs, b.wr_n, b.addr, b.data, m_busy[i], (qn[i] > 0 && b.kind == K_CLR), 16'(m_cnt[i])};
    got_v = {bw[i], busy[i], tick[i], cnt[i]};
    n_chk++;
    if (got_v !== exp_v) begin
      n_err++;
      $display("FAIL model inst%0d t=%0t got %h want %h", i, $time, got_v, exp_v);
    end
`ifdef SNAPSHOT_READ_EN
    n_chk++;
    if ({svld[i], sval[i]} !== {m_svld[i], m_sv[i]}) begin
      n_err++;
      $display("FAIL snap inst%0d t=%0t got %h want %h", i, $time, {svld[i], sval[i]}, {m_svld[i], m_sv[i]});
    end
`endif
  endtask

  task automatic chk(string name, logic [31:0] got, logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  // One clock: predict, let the edge happen, then check both instances off the edge
  task automatic cyc();
    for (int i = 0; i < 2; i++) advance(i);
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) compare(i);
    @(negedge clk);
  endtask

  task automatic cycles(int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  task automatic stop_all();
    cmd_stop = 1; cyc(); cmd_stop = 0;
    cycles(15);
  endtask

  initial begin
    int n;
    reset = 1; cmd_start = 0; cmd_stop = 0; cmd_cont = 0; irq = 0;
    cmd_period = 0; rdata = 0;
`ifdef SNAPSHOT_READ_EN
    snap_req = 0;
`endif
    cycles(2);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_bus0", 32'(bw[0]), 32'({1'b0, 1'b1, 3'd0, 16'd0}));
    chk("rst_cnt0", 32'(cnt[0]), 32'd0);
    reset = 0;
    cyc();

    // Program sequence: three consecutive writes
    cmd_period = 32'h0001_869F; cmd_cont = 1; cmd_start = 1;
    cyc();
    cmd_start = 0;
    chk("t1_perl", 32'(bw[0]), 32'({1'b1, 1'b0, 3'd2, 16'h869F}));
    chk("t1_busy", 32'(busy), 32'd3);
    cyc();
    chk("t1_perh", 32'(bw[0]), 32'({1'b1, 1'b0, 3'd3, 16'h0001}));
    cyc();
    chk("t1_ctrl_irq", 32'(bw[0]), 32'({1'b1, 1'b0, 3'd1, 16'h0007}));
    chk("t1_ctrl_poll", 32'(bw[1]), 32'({1'b1, 1'b0, 3'd1, 16'h0006}));
    cyc();

    // IRQ timeout -> one status clear and one tick
    irq = 1; cyc(); irq = 0;
    chk("t2_clr", 32'(bw[0]), 32'({1'b1, 1'b0, 3'd0, 16'd0}));
    chk("t2_tick", 32'(tick[0]), 32'd1);
    cyc();
    chk("t2_cnt", 32'(cnt[0]), 32'd1);
    cycles(4);
    chk("t2_no_second", 32'(cnt[0]), 32'd1);

    // Polling: one status read every POLL_GAP+2 cycles
    n = 0;
    while (!(bw[1][20] && bw[1][19]) && n < 40) begin cyc(); n++; end
    n = 0;
    do begin cyc(); n++; end while (!(bw[1][20] && bw[1][19]) && n < 40);
    chk("t3_gap", 32'(n), 32'd10);
    rdata = 16'h0001;
    n = 0;
    while (!tick[1] && n < 25) begin cyc(); n++; end
    rdata = 16'h0000;
    chk("t3_tick", 32'(tick[1]), 32'd1);
    cyc();
    chk("t3_cnt", 32'(cnt[1]), 32'd1);

    // Stop in the same cycle as a timeout: tick first, then stop, then flush
    irq = 1; cmd_stop = 1; cyc(); irq = 0; cmd_stop = 0;
    chk("t5_tick", 32'(tick[0]), 32'd1);
    cyc();
    chk("t5_stop", 32'(bw[0]), 32'({1'b1, 1'b0, 3'd1, 16'h0008}));
    cyc();
    chk("t5_flush", 32'(bw[0]), 32'({1'b1, 1'b0, 3'd0, 16'h0000}));
    chk("t5_flush_tick", 32'(tick[0]), 32'd0);
    cyc();
    chk("t5_idle", 32'(busy[0]), 32'd0);
    cycles(15);
    cmd_period = 0; cmd_start = 1; cyc(); cmd_start = 0;
    chk("t5_zero_period", 32'({busy, bw[0][20], bw[1][20]}), 32'd0);
    cycles(3);

    // One-shot: a single tick, then idle; later IRQs are ignored
    cmd_period = 32'd100; cmd_cont = 0; cmd_start = 1; cyc(); cmd_start = 0;
    cycles(3);
    irq = 1; cyc(); irq = 0;
    chk("t4_tick", 32'(tick[0]), 32'd1);
    cyc();
    chk("t4_idle", 32'(busy[0]), 32'd0);
    chk("t4_cnt", 32'(cnt[0]), 32'd1);
    irq = 1; cycles(2); irq = 0;
    chk("t4_ignored", 32'({tick[0], bw[0][20]}), 32'd0);
    stop_all();

`ifdef SNAPSHOT_READ_EN
    // Snapshot: the low half comes first, then the high half
    cmd_period = 32'd50; cmd_cont = 1; cmd_start = 1; cyc(); cmd_start = 0;
    cycles(4);
    snap_req = 1; cyc(); snap_req = 0;
    n = 0;
    while (bw[0] !== {1'b1, 1'b1, 3'd5, 16'd0} && n < 10) begin cyc(); n++; end
    rdata = 16'h1234; cyc();
    rdata = 16'h0005; cyc();
    chk("t6_value", sval[0], 32'h0005_1234);
    chk("t6_valid", 32'(svld[0]), 32'd1);
    rdata = 16'h0000; cyc();
    chk("t6_pulse", 32'(svld[0]), 32'd0);
    stop_all();
`endif

    // Randomized traffic against the model
    for (int k = 0; k < 4000; k++) begin
      reset      = ($urandom_range(0, 599) == 0);
      cmd_start  = ($urandom_range(0, 9) == 0);
      cmd_period = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      cmd_cont   = ($urandom_range(0, 2) != 0);
      cmd_stop   = ($urandom_range(0, 49) == 0);
      irq        = ($urandom_range(0, 5) == 0);
      rdata      = 16'($urandom);
      rdata[0]   = ($urandom_range(0, 3) == 0);
`ifdef SNAPSHOT_READ_EN
      snap_req   = ($urandom_range(0, 29) == 0);
`endif
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
